// File: rtl/pkt_tx_if.sv
// Upstream command/payload and router-side signals of the packet transmitter.
// The transmitter takes the master view and the traffic source takes the slave view.
interface pkt_tx_if;
    logic       start;
    logic [5:0] len;
    logic [1:0] addr;
    logic       corrupt;
    logic [7:0] src_data;
    logic       src_valid;
    logic       src_ready;
    logic       busy;
    logic [7:0] d_out;
    logic       pkt_valid;
    logic       tx_busy;
    logic       done;
    logic       cmd_err;

    modport master (
        input  start, len, addr, corrupt, src_data, src_valid, busy,
        output src_ready, d_out, pkt_valid, tx_busy, done, cmd_err
    );

    modport slave (
        output start, len, addr, corrupt, src_data, src_valid, busy,
        input  src_ready, d_out, pkt_valid, tx_busy, done, cmd_err
    );
endinterface

// File: rtl/pkt_tx.sv
// Router packet source: buffers a command plus its payload, then sends the header,
// the payload and a parity byte, holding the current byte while the router is busy.
module pkt_tx #(
    parameter int unsigned MAX_LEN = 63
) (
    input  logic     clk,
    input  logic     rst,
    pkt_tx_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PAY,
        S_PAR
    } state_e;

    state_e     state_q, state_d;
    logic [5:0] len_q, len_d;
    logic [5:0] wcnt_q, wcnt_d;
    logic [5:0] rcnt_q, rcnt_d;
    logic [7:0] hdr_q, hdr_d;
    logic [7:0] par_q, par_d;
    logic       corrupt_q, corrupt_d;
    logic [7:0] d_out_q, d_out_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       src_ready_q, src_ready_d;
    logic       tx_busy_q, tx_busy_d;
    logic       done_q, done_d;
    logic       cmd_err_q, cmd_err_d;

    logic [7:0] pay_buf_q [MAX_LEN];

    logic cmd_ok_c;
    logic load_hs_c;
    logic load_last_c;
    logic accept_c;

    assign cmd_ok_c    = (bus.len != 6'd0) && (bus.addr != 2'd3) &&
                         (32'(bus.len) <= MAX_LEN);
    assign load_hs_c   = (state_q == S_LOAD) && bus.src_valid && src_ready_q;
    assign load_last_c = load_hs_c && (wcnt_q == len_q - 6'd1);
    assign accept_c    = !bus.busy;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (bus.start && cmd_ok_c) state_d = S_LOAD;
            S_LOAD:  if (load_last_c) state_d = S_HDR;
            S_HDR:   if (accept_c) state_d = S_PAY;
            S_PAY:   if (accept_c && (rcnt_q == len_q)) state_d = S_PAR;
            S_PAR:   if (accept_c) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values
    always_comb begin
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        hdr_d       = hdr_q;
        par_d       = par_q;
        corrupt_d   = corrupt_q;
        d_out_d     = d_out_q;
        pkt_valid_d = pkt_valid_q;
        src_ready_d = src_ready_q;
        tx_busy_d   = tx_busy_q;
        done_d      = 1'b0;
        cmd_err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (cmd_ok_c) begin
                        len_d       = bus.len;
                        corrupt_d   = bus.corrupt;
                        hdr_d       = {bus.len, bus.addr};
                        par_d       = {bus.len, bus.addr};
                        wcnt_d      = 6'd0;
                        src_ready_d = 1'b1;
                        tx_busy_d   = 1'b1;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (load_hs_c) begin
                    par_d  = par_q ^ bus.src_data;
                    wcnt_d = wcnt_q + 6'd1;
                end
                // Header goes out on the same edge as the final payload write
                if (load_last_c) begin
                    src_ready_d = 1'b0;
                    pkt_valid_d = 1'b1;
                    d_out_d     = hdr_q;
                end
            end
            S_HDR: begin
                if (accept_c) begin
                    d_out_d = pay_buf_q[0];
                    rcnt_d  = 6'd1;
                end
            end
            S_PAY: begin
                if (accept_c) begin
                    if (rcnt_q < len_q) begin
                        d_out_d = pay_buf_q[rcnt_q];
                        rcnt_d  = rcnt_q + 6'd1;
                    end else begin
                        pkt_valid_d = 1'b0;
                        d_out_d     = corrupt_q ? ~par_q : par_q;
                    end
                end
            end
            S_PAR: begin
                if (accept_c) begin
                    d_out_d   = 8'h00;
                    done_d    = 1'b1;
                    tx_busy_d = 1'b0;
                end
            end
            default: begin
                tx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            len_q       <= 6'd0;
            wcnt_q      <= 6'd0;
            rcnt_q      <= 6'd0;
            hdr_q       <= 8'h00;
            par_q       <= 8'h00;
            corrupt_q   <= 1'b0;
            d_out_q     <= 8'h00;
            pkt_valid_q <= 1'b0;
            src_ready_q <= 1'b0;
            tx_busy_q   <= 1'b0;
            done_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            len_q       <= len_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            hdr_q       <= hdr_d;
            par_q       <= par_d;
            corrupt_q   <= corrupt_d;
            d_out_q     <= d_out_d;
            pkt_valid_q <= pkt_valid_d;
            src_ready_q <= src_ready_d;
            tx_busy_q   <= tx_busy_d;
            done_q      <= done_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    // Payload storage carries no reset; entries are always written before being read
    always_ff @(posedge clk) begin
        if (load_hs_c) begin
            pay_buf_q[wcnt_q] <= bus.src_data;
        end
    end

    assign bus.d_out     = d_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.src_ready = src_ready_q;
    assign bus.tx_busy   = tx_busy_q;
    assign bus.done      = done_q;
    assign bus.cmd_err   = cmd_err_q;
endmodule

// File: tb/tb_pkt_tx.sv
// Bench for pkt_tx: a packet-level reference model predicts every output each cycle,
// plus literal expectations for the directed scenarios and a randomized traffic phase.
module tb_pkt_tx;
    logic clk = 1'b0;
    logic rst;

    pkt_tx_if bus_if ();

    pkt_tx #(.MAX_LEN(63)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.master)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: packet as a byte stream, advanced one entry per accepted byte
    int         m_phase = 0;   // 0 idle, 1 collecting payload, 2 sending stream
    int         m_len;
    int         m_idx;
    logic [7:0] m_hdr;
    bit         m_cor;
    logic [7:0] pay_q[$];
    logic [7:0] s_byte[$];
    bit         s_pv[$];
    logic [7:0] cap_q[$];
    int         n22;
    bit         chk_en = 1'b0;
    logic [7:0] e_dout;
    logic       e_pv, e_srdy, e_txb, e_done, e_err;

    always @(posedge clk) begin
        if (!rst) begin
            m_phase = 0;
            e_dout = 8'h00; e_pv = 1'b0; e_srdy = 1'b0; e_txb = 1'b0;
            e_done = 1'b0;  e_err = 1'b0;
            pay_q.delete();
            chk_en = 1'b1;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b0;
            case (m_phase)
                0: if (bus_if.start) begin
                    if (bus_if.len == 6'd0 || bus_if.addr == 2'd3) begin
                        e_err = 1'b1;
                    end else begin
                        m_len = int'(bus_if.len);
                        m_hdr = {bus_if.len, bus_if.addr};
                        m_cor = bus_if.corrupt;
                        pay_q.delete();
                        e_srdy = 1'b1; e_txb = 1'b1;
                        m_phase = 1;
                    end
                end
                1: if (bus_if.src_valid && e_srdy) begin
                    pay_q.push_back(bus_if.src_data);
                    if (pay_q.size() == m_len) begin
                        logic [7:0] p;
                        p = m_hdr;
                        s_byte.delete(); s_pv.delete();
                        s_byte.push_back(m_hdr); s_pv.push_back(1'b1);
                        foreach (pay_q[i]) begin
                            p ^= pay_q[i];
                            s_byte.push_back(pay_q[i]); s_pv.push_back(1'b1);
                        end
                        s_byte.push_back(m_cor ? ~p : p); s_pv.push_back(1'b0);
                        m_idx = 0;
                        e_srdy = 1'b0; e_dout = s_byte[0]; e_pv = 1'b1;
                        m_phase = 2;
                    end
                end
                2: begin
                    if (bus_if.d_out == 8'h22 && bus_if.pkt_valid) n22++;
                    if (!bus_if.busy) begin
                        cap_q.push_back(bus_if.d_out);
                        m_idx++;
                        if (m_idx == s_byte.size()) begin
                            e_dout = 8'h00; e_pv = 1'b0; e_done = 1'b1; e_txb = 1'b0;
                            m_phase = 0;
                        end else begin
                            e_dout = s_byte[m_idx]; e_pv = s_pv[m_idx];
                        end
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("d_out",     32'(bus_if.d_out),     32'(e_dout));
            chk("pkt_valid", 32'(bus_if.pkt_valid), 32'(e_pv));
            chk("src_ready", 32'(bus_if.src_ready), 32'(e_srdy));
            chk("tx_busy",   32'(bus_if.tx_busy),   32'(e_txb));
            chk("done",      32'(bus_if.done),      32'(e_done));
            chk("cmd_err",   32'(bus_if.cmd_err),   32'(e_err));
        end
    end

    logic [7:0] pl [64];

    task automatic do_cmd(input int l, input int a, input bit c, output bit ok);
        bus_if.start   = 1'b1;
        bus_if.len     = 6'(l);
        bus_if.addr    = 2'(a);
        bus_if.corrupt = c;
        cap_q.delete();
        n22 = 0;
        @(negedge clk);
        bus_if.start = 1'b0;
        ok = (l != 0) && (a != 3);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random valid with random busy
    task automatic load(input int l, input int vmode);
        int fed = 0;
        int budget = 0;
        bit tog = 1'b1;
        while (fed < l && budget < 1000) begin
            case (vmode)
                0: bus_if.src_valid = 1'b1;
                1: begin bus_if.src_valid = tog; tog = ~tog; end
                default: begin
                    bus_if.src_valid = 1'($urandom_range(0, 1));
                    bus_if.busy      = 1'($urandom_range(0, 1));
                end
            endcase
            bus_if.src_data = pl[fed];
            @(posedge clk);
            if (bus_if.src_valid && bus_if.src_ready) fed++;
            @(negedge clk);
            budget++;
        end
        bus_if.src_valid = 1'b0;
        bus_if.busy      = 1'b0;
        if (fed < l) chk("load_timeout", 32'(fed), 32'(l));
    endtask

    // bmode: 0 never busy, 1 busy 3 cycles while 0x22 is shown, 2 random busy
    task automatic send(input int bmode);
        int budget = 0;
        int held = 0;
        while (m_phase != 0 && budget < 1000) begin
            case (bmode)
                0: bus_if.busy = 1'b0;
                1: if (bus_if.d_out == 8'h22 && held < 3) begin
                       bus_if.busy = 1'b1; held++;
                   end else begin
                       bus_if.busy = 1'b0;
                   end
                default: bus_if.busy = ($urandom_range(0, 9) < 3);
            endcase
            @(negedge clk);
            budget++;
        end
        bus_if.busy = 1'b0;
        if (m_phase != 0) chk("send_timeout", 32'(m_phase), 32'd0);
    endtask

    task automatic chk_cap(input string tag, input logic [7:0] exp [], input int n);
        chk({tag, "_count"}, 32'(cap_q.size()), 32'(n));
        for (int i = 0; i < n && i < cap_q.size(); i++)
            chk($sformatf("%s_byte%0d", tag, i), 32'(cap_q[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [7:0] e1 [];
        logic [7:0] e3 [];
        logic [7:0] e6 [];
        bit ok;
        int budget;
        e1 = new[6];
        e1[0] = 8'h11; e1[1] = 8'h11; e1[2] = 8'h22;
        e1[3] = 8'h33; e1[4] = 8'h44; e1[5] = 8'h55;
        e3 = new[6];
        foreach (e1[i]) e3[i] = e1[i];
        e3[5] = 8'hAA;
        e6 = new[3];
        e6[0] = 8'h04; e6[1] = 8'h5A; e6[2] = 8'h5E;

        rst = 1'b0;
        bus_if.start = 1'b0; bus_if.len = 6'd0; bus_if.addr = 2'd0; bus_if.corrupt = 1'b0;
        bus_if.src_data = 8'h00; bus_if.src_valid = 1'b0; bus_if.busy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_d_out",     32'(bus_if.d_out),     32'd0);
        chk("rst_pkt_valid", 32'(bus_if.pkt_valid), 32'd0);
        chk("rst_tx_busy",   32'(bus_if.tx_busy),   32'd0);
        chk("rst_src_ready", 32'(bus_if.src_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic packet, no stalls
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        do_cmd(4, 1, 1'b0, ok);
        load(4, 0);
        send(0);
        chk("s1_done", 32'(bus_if.done), 32'd1);
        chk_cap("s1", e1, 6);

        // Router stall on 0x22
        do_cmd(4, 1, 1'b0, ok);
        load(4, 0);
        send(1);
        chk_cap("s2", e1, 6);
        chk("s2_hold22", 32'(n22), 32'd4);

        // Corrupted parity
        do_cmd(4, 1, 1'b1, ok);
        load(4, 0);
        send(0);
        chk_cap("s3", e3, 6);

        // Illegal commands
        @(negedge clk);
        do_cmd(4, 3, 1'b0, ok);
        chk("s4_err_addr", 32'(bus_if.cmd_err), 32'd1);
        chk("s4_busy_addr", 32'(bus_if.tx_busy), 32'd0);
        do_cmd(0, 1, 1'b0, ok);
        chk("s4_err_len", 32'(bus_if.cmd_err), 32'd1);
        chk("s4_rdy_len", 32'(bus_if.src_ready), 32'd0);
        @(negedge clk);
        chk("s4_err_clear", 32'(bus_if.cmd_err), 32'd0);

        // Maximum length with gappy source
        for (int i = 0; i < 63; i++) pl[i] = 8'($urandom);
        do_cmd(63, 2, 1'b0, ok);
        load(63, 1);
        chk("s5_hdr", 32'(bus_if.d_out), 32'hFE);
        send(0);
        chk("s5_count", 32'(cap_q.size()), 32'd65);

        // Reset in the middle of the payload
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33; pl[3] = 8'h44;
        do_cmd(4, 1, 1'b0, ok);
        load(4, 0);
        budget = 0;
        while (m_idx < 2 && budget < 20) begin @(negedge clk); budget++; end
        chk("s6_in_pay", 32'(bus_if.d_out), 32'h22);
        rst = 1'b0;
        @(negedge clk);
        chk("s6_pv",   32'(bus_if.pkt_valid), 32'd0);
        chk("s6_dout", 32'(bus_if.d_out),     32'd0);
        chk("s6_txb",  32'(bus_if.tx_busy),   32'd0);
        rst = 1'b1;
        pl[0] = 8'h5A;
        do_cmd(1, 0, 1'b0, ok);
        load(1, 0);
        send(0);
        chk_cap("s6", e6, 3);

        // Randomized traffic, back-to-back starts on the done cycle
        for (int k = 0; k < 25; k++) begin
            int l;
            int a;
            l = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
            a = int'($urandom_range(0, 3));
            for (int i = 0; i < 64; i++) pl[i] = 8'($urandom);
            do_cmd(l, a, 1'($urandom_range(0, 1)), ok);
            if (ok) begin
                load(l, 2);
                send(2);
            end
        end
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
